id_gen: RTL and testbench

- Character-stream generator: the transmit-side counterpart of the identifier recognizer FSM.
- On a start command it emits one token, one 8-bit ASCII character per accepted handshake: a run of letters, then a run of digits, then a single space delimiter.
- Used as the stimulus source that drives the recognizer's char/clk inputs in system-level tests and self-check loops.
- Also exports the recognizer output the token must produce, for scoreboarding.

---
 rtl/id_gen_pkg.sv | 24 ++
 rtl/id_gen_if.sv | 10 +
 rtl/id_gen_wrapcnt.sv | 29 ++
 rtl/id_gen.sv | 142 ++++++++++++++
 tb/tb_id_gen.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/id_gen_pkg.sv
// Shared constants and state encoding for the identifier token generator.
// ASCII anchors, alphabet/digit moduli and the 2-bit FSM state type.
package id_gen_pkg;

    localparam logic [7:0] CH_UPPER_A = 8'd65;
    localparam logic [7:0] CH_LOWER_A = 8'd97;
    localparam logic [7:0] CH_ZERO    = 8'd48;
    localparam logic [7:0] CH_SPACE   = 8'd32;
    localparam int         ALPHA_CNT  = 26;
    localparam int         DIGIT_CNT  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALPHA = 2'd1,
        DIGIT = 2'd2,
        DELIM = 2'd3
    } state_t;

    // Out-of-range letter indices start the run at 'a'/'A'.
    function automatic logic [4:0] clamp_alpha(input logic [4:0] idx);
        return (idx > 5'd25) ? 5'd0 : idx;
    endfunction

endpackage

// File: rtl/id_gen_if.sv
// Character stream handshake between the token generator and its sink.
// Transfer occurs on any cycle with char_valid & char_ready.
interface id_gen_if;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;

    modport master (output char_out, output char_valid, input char_ready);
    modport slave  (input char_out, input char_valid, output char_ready);
endinterface

// File: rtl/id_gen_wrapcnt.sv
// Modulo-N up-counter with synchronous load (priority) and step enable.
// Count is registered; a step from N-1 returns to 0.
module id_gen_wrapcnt #(
    parameter int N = 26,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= (cnt_q == W'(N - 1)) ? '0 : cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_gen.sv
// Emits one identifier-shaped token (letters, digits, space) per accepted start.
// First char valid the cycle after start; char_out and state hold while char_ready is low.
module id_gen
    import id_gen_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] alpha_len,
    input  logic [LEN_W-1:0] digit_len,
    input  logic [4:0]       first_alpha,
    input  logic             upper,
    id_gen_if.master         chr,
    output logic             busy,
    output logic             done,
    output logic             expect_id
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] alpha_rem_q, digit_rem_q;
    logic             upper_q;
    logic             expect_q;
    logic             done_q;
    logic [4:0]       letter_idx;
    logic [3:0]       digit_idx;
    logic [7:0]       char_c;
    logic             valid_c;
    logic             xfer;
    logic             accept;
    logic             alpha_step;
    logic             digit_step;

    assign xfer       = valid_c & chr.char_ready;
    assign accept     = (state_q == IDLE) & start;
    assign alpha_step = (state_q == ALPHA) & xfer;
    assign digit_step = (state_q == DIGIT) & xfer;

    id_gen_wrapcnt #(.N(ALPHA_CNT), .W(5)) u_letter_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (clamp_alpha(first_alpha)),
        .en       (alpha_step),
        .cnt      (letter_idx)
    );

    // Digits restart at '0' for every token regardless of where the last one ended.
    id_gen_wrapcnt #(.N(DIGIT_CNT), .W(4)) u_digit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (4'd0),
        .en       (digit_step),
        .cnt      (digit_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        char_c  = 8'd0;
        valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (alpha_len != '0) begin
                        state_d = ALPHA;
                    end else if (digit_len != '0) begin
                        state_d = DIGIT;
                    end else begin
                        state_d = DELIM;
                    end
                end
            end
            ALPHA: begin
                valid_c = 1'b1;
                char_c  = (upper_q ? CH_UPPER_A : CH_LOWER_A) + {3'b000, letter_idx};
                if (chr.char_ready && alpha_rem_q == LEN_W'(1)) begin
                    state_d = (digit_rem_q != '0) ? DIGIT : DELIM;
                end
            end
            DIGIT: begin
                valid_c = 1'b1;
                char_c  = CH_ZERO + {4'b0000, digit_idx};
                if (chr.char_ready && digit_rem_q == LEN_W'(1)) begin
                    state_d = DELIM;
                end
            end
            DELIM: begin
                valid_c = 1'b1;
                char_c  = CH_SPACE;
                if (chr.char_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Remaining-count registers run down to 1; the transfer at 1 ends the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alpha_rem_q <= '0;
            digit_rem_q <= '0;
            upper_q     <= 1'b0;
            expect_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == DELIM) & xfer;
            if (accept) begin
                alpha_rem_q <= alpha_len;
                digit_rem_q <= digit_len;
                upper_q     <= upper;
                expect_q    <= (alpha_len != '0) & (digit_len != '0);
            end else begin
                if (alpha_step) begin
                    alpha_rem_q <= alpha_rem_q - LEN_W'(1);
                end
                if (digit_step) begin
                    digit_rem_q <= digit_rem_q - LEN_W'(1);
                end
            end
        end
    end

    assign chr.char_out   = char_c;
    assign chr.char_valid = valid_c;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign expect_id      = expect_q;

endmodule

// File: tb/tb_id_gen.sv
// Directed bench for id_gen: token contents, latency, stalls, resets and edge starts.
module tb_id_gen;
    import id_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] alpha_len = '0;
    logic [3:0] digit_len = '0;
    logic [4:0] first_alpha = '0;
    logic       upper = 1'b0;
    logic       busy, done, expect_id;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    id_gen_if ch();

    id_gen #(.LEN_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .alpha_len   (alpha_len),
        .digit_len   (digit_len),
        .first_alpha (first_alpha),
        .upper       (upper),
        .chr         (ch),
        .busy        (busy),
        .done        (done),
        .expect_id   (expect_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present start for one edge, then confirm the first character is already valid.
    task automatic send(input logic [3:0] al, input logic [3:0] dl, input logic [4:0] fa,
                        input logic up);
        start = 1'b1; alpha_len = al; digit_len = dl; first_alpha = fa; upper = up;
        @(negedge clk);
        start = 1'b0;
        chk("first_valid", 32'(ch.char_valid), 32'd1);
        chk("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic collect(input int n, input bit rnd);
        int cyc;
        logic [7:0] held;
        bit stalled;
        cyc = 0; stalled = 1'b0; held = '0;
        while (got_q.size() < n && cyc < 200) begin
            ch.char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk("stall_hold", 32'(ch.char_out), 32'(held));
            end
            if (ch.char_valid && ch.char_ready) begin
                got_q.push_back(ch.char_out);
                stalled = 1'b0;
            end else begin
                stalled = ch.char_valid;
                held    = ch.char_out;
            end
            @(negedge clk);
            cyc++;
        end
        ch.char_ready = 1'b1;
        chk("xfer_count", 32'(got_q.size()), 32'(n));
    endtask

    task automatic compare(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i),
                (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
        got_q.delete();
    endtask

    task automatic end_chk(input bit pulse_only);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("valid_fall", 32'(ch.char_valid), 32'd0);
        if (pulse_only) begin
            @(negedge clk);
            chk("done_one_cycle", 32'(done), 32'd0);
        end
    endtask

    initial begin
        ch.char_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(ch.char_valid), 32'd0);
        chk("rst_char", 32'(ch.char_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_expect", 32'(expect_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-token: abort after two transfers of "abc012 "
        send(4'd3, 4'd3, 5'd0, 1'b0);
        collect(2, 1'b0);
        exp_q = '{8'd97, 8'd98};
        compare("mid_rst");
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(ch.char_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_char", 32'(ch.char_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end

        // "ab012 " with back-to-back "YZA " started in the done cycle
        send(4'd2, 4'd3, 5'd0, 1'b0);
        chk("expect_t2", 32'(expect_id), 32'd1);
        collect(6, 1'b0);
        exp_q = '{8'd97, 8'd98, 8'd48, 8'd49, 8'd50, 8'd32};
        compare("tok_ab012");
        end_chk(1'b0);
        send(4'd3, 4'd0, 5'd24, 1'b1);
        chk("expect_t3", 32'(expect_id), 32'd0);
        collect(4, 1'b0);
        exp_q = '{8'd89, 8'd90, 8'd65, 8'd32};
        compare("tok_YZA");
        end_chk(1'b1);

        // Twelve digits: wraps 9->0 and restarts at '0' per token
        send(4'd0, 4'd12, 5'd7, 1'b0);
        chk("expect_t4", 32'(expect_id), 32'd0);
        collect(13, 1'b0);
        exp_q = '{8'd48, 8'd49, 8'd50, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57,
                  8'd48, 8'd49, 8'd32};
        compare("tok_digits");
        end_chk(1'b1);

        // Random backpressure: "DEFG0123 "
        send(4'd4, 4'd4, 5'd3, 1'b1);
        chk("expect_t5", 32'(expect_id), 32'd1);
        collect(9, 1'b1);
        exp_q = '{8'd68, 8'd69, 8'd70, 8'd71, 8'd48, 8'd49, 8'd50, 8'd51, 8'd32};
        compare("tok_stall");
        end_chk(1'b1);
        chk("expect_hold", 32'(expect_id), 32'd1);

        // Both lengths zero: a lone space
        send(4'd0, 4'd0, 5'd0, 1'b0);
        collect(1, 1'b0);
        exp_q = '{8'd32};
        compare("tok_empty");
        end_chk(1'b1);
        chk("expect_empty", 32'(expect_id), 32'd0);

        // Clamped letter index and start pulsed while busy
        send(4'd2, 4'd1, 5'd30, 1'b0);
        chk("expect_t7", 32'(expect_id), 32'd1);
        start = 1'b1; alpha_len = 4'd5; digit_len = 4'd0;
        collect(1, 1'b0);
        start = 1'b0;
        collect(4, 1'b0);
        exp_q = '{8'd97, 8'd98, 8'd48, 8'd32};
        compare("tok_clamp_busy");
        end_chk(1'b1);
        chk("no_restart", 32'(busy), 32'd0);
        chk("expect_kept", 32'(expect_id), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
